// File: rtl/adsr_envelope_pkg.sv
// Shared state encodings and helpers for the ADSR envelope stage.
// Imported by the envelope top and its prescaler.
package adsr_envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam logic [7:0] LEVEL_MAX = 8'hFF;
  localparam logic [7:0] LEVEL_MIN = 8'h00;

  // IDLE and SUSTAIN never step, so their rate is irrelevant.
  function automatic logic [3:0] rate_sel(
    input adsr_state_e st,
    input logic [3:0]  a,
    input logic [3:0]  d,
    input logic [3:0]  r
  );
    logic [3:0] v;
    v = 4'd0;
    unique case (st)
      ST_ATTACK:  v = a;
      ST_DECAY:   v = d;
      ST_RELEASE: v = r;
      default:    v = 4'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/adsr_envelope_tick_prescaler.sv
// Free-running prescaler: one-clk tick every 2**PRESC_W cycles.
// Not cleared by anything but reset, so the time base never jitters.
module tick_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  logic [PRESC_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = &r_cnt;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator feeding the PWM duty input.
// Level is registered, so downstream may sample on any cycle.
module adsr_envelope
  import adsr_envelope_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic [3:0] attack_rate,
  input  logic [3:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [3:0] release_rate,
  output logic [7:0] level,
  output logic [2:0] state,
  output logic       active
);

  adsr_state_e r_state;
  logic [7:0]  r_level;
  logic [3:0]  r_rate_cnt;
  logic        r_gate_q;

  adsr_state_e w_nxt_state;
  logic [7:0]  w_nxt_level;
  logic [3:0]  w_nxt_cnt;
  logic [3:0]  w_rate;
  logic [3:0]  w_cnt_adv;
  logic        w_tick;
  logic        w_step;
  logic        w_rise;

  tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_rise = gate & ~r_gate_q;
  assign w_rate = rate_sel(r_state, attack_rate,
                           decay_rate, release_rate);
  assign w_step = w_tick & (r_rate_cnt == w_rate);

  always_comb begin
    w_cnt_adv = r_rate_cnt;
    if (w_tick) begin
      if (w_step) w_cnt_adv = 4'd0;
      else        w_cnt_adv = r_rate_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_level    <= LEVEL_MIN;
      r_rate_cnt <= 4'd0;
      r_gate_q   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_level    <= w_nxt_level;
      r_rate_cnt <= w_nxt_cnt;
      r_gate_q   <= gate;
    end
  end

  // Retrigger keeps the level so a re-pressed note does not click.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_level = r_level;
    w_nxt_cnt   = w_cnt_adv;
    if (w_rise) begin
      w_nxt_state = ST_ATTACK;
      w_nxt_cnt   = 4'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_nxt_level = LEVEL_MIN;
        end
        ST_ATTACK: begin
          if (!gate) begin
            w_nxt_state = ST_RELEASE;
            w_nxt_cnt   = 4'd0;
          end else if (r_level == LEVEL_MAX) begin
            w_nxt_state = ST_DECAY;
            w_nxt_cnt   = 4'd0;
          end else if (w_step) begin
            w_nxt_level = r_level + 8'd1;
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            w_nxt_state = ST_RELEASE;
            w_nxt_cnt   = 4'd0;
          end else if (r_level <= sustain_level) begin
            w_nxt_state = ST_SUSTAIN;
            w_nxt_cnt   = 4'd0;
          end else if (w_step) begin
            w_nxt_level = r_level - 8'd1;
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            w_nxt_state = ST_RELEASE;
            w_nxt_cnt   = 4'd0;
          end else begin
            w_nxt_level = sustain_level;
          end
        end
        ST_RELEASE: begin
          if (r_level == LEVEL_MIN) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = 4'd0;
          end else if (w_step) begin
            w_nxt_level = r_level - 8'd1;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_level = LEVEL_MIN;
          w_nxt_cnt   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    level  = r_level;
    state  = r_state;
    active = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: vector table, corner sequences,
// and a random run against a cycle-level envelope model.
module tb_adsr_envelope;

  localparam int PW   = 2;
  localparam int TDIV = 1 << PW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gate = 1'b0;
  logic [3:0] attack_rate = '0;
  logic [3:0] decay_rate = '0;
  logic [7:0] sustain_level = '0;
  logic [3:0] release_rate = '0;
  logic [7:0] level;
  logic [2:0] state;
  logic       active;

  adsr_envelope #(.PRESC_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .level         (level),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    gate = 1'b0;
    clks(3);
    rst  = 1'b0;
  endtask

  // Envelope model: phases 0..4, step when waited ticks hit the rate.
  int m_level = 0;
  int m_ph    = 0;
  int m_wait  = 0;
  int m_div   = 0;
  bit m_gq    = 0;

  always @(posedge clk) begin : p_model
    int rate;
    bit tick;
    bit rise;
    bit step;
    if (rst) begin
      m_level = 0; m_ph = 0; m_wait = 0; m_div = 0; m_gq = 0;
    end else begin
      tick  = (m_div == TDIV - 1);
      m_div = (m_div + 1) % TDIV;
      rise  = gate && !m_gq;
      m_gq  = gate;
      rate  = (m_ph == 1) ? int'(attack_rate) :
              (m_ph == 2) ? int'(decay_rate) :
              (m_ph == 4) ? int'(release_rate) : 0;
      step = 0;
      if (tick) begin
        if (m_wait == rate) begin
          step = 1; m_wait = 0;
        end else begin
          m_wait = (m_wait + 1) % 16;
        end
      end
      if (rise) begin
        m_ph = 1; m_wait = 0;
      end else if (m_ph == 0) begin
        m_level = 0;
      end else if (m_ph == 4) begin
        if (m_level == 0) begin m_ph = 0; m_wait = 0; end
        else if (step) m_level = m_level - 1;
      end else if (!gate) begin
        m_ph = 4; m_wait = 0;
      end else if (m_ph == 1) begin
        if (m_level == 255) begin m_ph = 2; m_wait = 0; end
        else if (step) m_level = m_level + 1;
      end else if (m_ph == 2) begin
        if (m_level <= int'(sustain_level)) begin m_ph = 3; m_wait = 0; end
        else if (step) m_level = m_level - 1;
      end else begin
        m_level = int'(sustain_level);
      end
    end
  end

  typedef struct {
    bit g;
    int a;
    int d;
    int s;
    int r;
    int n;
    int lvl;
    int st;
  } vec_t;

  vec_t tbl[14];
  int   mx;
  int   e;

  initial begin
    // Full envelope checkpoints, cycles counted from the last reset edge.
    tbl[0]  = '{1, 0, 0, 128, 0,   1,   0, 1};
    tbl[1]  = '{1, 0, 0, 128, 0,   3,   1, 1};
    tbl[2]  = '{1, 0, 0, 128, 0, 400, 101, 1};
    tbl[3]  = '{1, 0, 0, 128, 0, 616, 255, 1};
    tbl[4]  = '{1, 0, 0, 128, 0,   1, 255, 2};
    tbl[5]  = '{1, 0, 0, 128, 0,   3, 254, 2};
    tbl[6]  = '{1, 0, 0, 128, 0, 504, 128, 2};
    tbl[7]  = '{1, 0, 0, 128, 0,   1, 128, 3};
    tbl[8]  = '{1, 0, 0, 128, 0,  50, 128, 3};
    tbl[9]  = '{0, 0, 0, 128, 0,   1, 128, 4};
    tbl[10] = '{0, 0, 0, 128, 0,   4, 127, 4};
    tbl[11] = '{0, 0, 0, 128, 0, 508,   0, 4};
    tbl[12] = '{0, 0, 0, 128, 0,   1,   0, 0};
    tbl[13] = '{0, 0, 0, 128, 0,  10,   0, 0};

    @(negedge clk);

    // Reset mid-attack
    do_reset();
    gate = 1'b1;
    clks(50);
    chk("rst_pre_level", level, 12);
    chk("rst_pre_state", state, 1);
    rst = 1'b1;
    clks(3);
    chk("rst_level", level, 0);
    chk("rst_state", state, 0);
    chk("rst_active", active, 0);
    rst  = 1'b0;
    gate = 1'b0;
    clks(20);
    chk("rst_idle_state", state, 0);
    chk("rst_idle_level", level, 0);

    // Vector table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      gate          = tbl[i].g;
      attack_rate   = 4'(tbl[i].a);
      decay_rate    = 4'(tbl[i].d);
      sustain_level = 8'(tbl[i].s);
      release_rate  = 4'(tbl[i].r);
      clks(tbl[i].n);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
    end

    // Rate scaling: attack_rate=3 steps once per 16 clk
    do_reset();
    attack_rate = 4'd3;
    gate = 1'b1;
    e = 0;
    for (int k = 1; k <= 10; k++) begin
      clks(16 * k - 1 - e);
      chk($sformatf("rate_pre%0d", k), level, k - 1);
      clks(1);
      chk($sformatf("rate_at%0d", k), level, k);
      e = 16 * k;
    end
    attack_rate = 4'd0;

    // Retrigger during release keeps the level
    do_reset();
    gate = 1'b1;
    clks(800);
    chk("retrig_top", level, 200);
    gate = 1'b0;
    clks(1);
    chk("retrig_rel_state", state, 4);
    chk("retrig_rel_level", level, 200);
    clks(19);
    chk("retrig_5steps", level, 195);
    gate = 1'b1;
    clks(1);
    chk("retrig_state", state, 1);
    chk("retrig_level", level, 195);
    clks(3);
    chk("retrig_step", level, 196);

    // Sustain at 255 and live sustain changes
    do_reset();
    sustain_level = 8'd255;
    gate = 1'b1;
    clks(1020);
    chk("s255_att", state, 1);
    clks(1);
    chk("s255_dec", state, 2);
    clks(1);
    chk("s255_sus", state, 3);
    chk("s255_lvl", level, 255);
    sustain_level = 8'd128;
    clks(1);
    chk("live_down", level, 128);
    sustain_level = 8'd200;
    clks(1);
    chk("live_up", level, 200);
    chk("live_state", state, 3);

    // Sustain at 0
    do_reset();
    sustain_level = 8'd0;
    gate = 1'b1;
    clks(2040);
    chk("s0_dec_level", level, 0);
    chk("s0_dec_state", state, 2);
    clks(1);
    chk("s0_sus_state", state, 3);
    clks(8);
    chk("s0_hold_level", level, 0);
    chk("s0_hold_state", state, 3);
    gate = 1'b0;
    clks(1);
    chk("s0_rel_state", state, 4);
    clks(1);
    chk("s0_idle_state", state, 0);
    chk("s0_idle_active", active, 0);

    // Early release from attack
    do_reset();
    sustain_level = 8'd128;
    gate = 1'b1;
    clks(200);
    chk("early_top", level, 50);
    gate = 1'b0;
    clks(1);
    chk("early_rel_state", state, 4);
    mx = level;
    for (int i = 0; i < 199; i++) begin
      clks(1);
      if (level > mx) mx = level;
    end
    chk("early_max", mx, 50);
    chk("early_end_level", level, 0);
    chk("early_end_state", state, 4);
    clks(1);
    chk("early_idle", state, 0);

    // Random run against the model
    do_reset();
    attack_rate   = 4'($urandom_range(0, 2));
    decay_rate    = 4'($urandom_range(0, 2));
    release_rate  = 4'($urandom_range(0, 2));
    sustain_level = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 399) == 0) gate = ~gate;
      if ($urandom_range(0, 99) == 0)
        attack_rate = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)
        decay_rate = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)
        release_rate = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0)
        sustain_level = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 2999) == 0);
      clks(1);
      chk("rnd_level", level, m_level);
      chk("rnd_state", state, m_ph);
      chk("rnd_active", active, int'(m_ph != 0));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
